// File: rtl/cl_serialize_if.sv
// Pixel stream handshake between a video source and the Camera Link transmitter.
// tdata[15:8] carries port A, tdata[7:0] port B.
interface cl_serialize_if #(
  parameter int unsigned DataWidth = 16
);
  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tuser;
  logic                 tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/cl_serialize.sv
// Camera Link base-configuration transmitter: maps a 16-bit pixel stream onto the 28-bit
// channel-link word and generates FVAL/LVAL/DVAL with horizontal and vertical blanking.
module cl_serialize #(
  parameter int unsigned VID_DATA_SIZE = 16,
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_BLANK       = 32,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned VBLANK_CYCLES = 2048
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                enable,
  input  logic                err_clr,
  cl_serialize_if.slave       s_axis,
  output logic [27:0]         Data,
  output logic                frame_done,
  output logic                err_sof,
  output logic                err_eol
);

  localparam int unsigned BMax = (H_BLANK > VBLANK_CYCLES) ? H_BLANK : VBLANK_CYCLES;
  localparam int unsigned PW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned LW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BW   = (BMax > 1) ? $clog2(BMax) : 1;

  localparam logic [PW-1:0] PixLast    = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LineLast   = LW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] HBlankLast = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VBlankLast = BW'(VBLANK_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLead, StLine, StHblank, StVblank} state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] line_q, line_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [27:0] data_q, data_d;
  logic        frame_done_q, frame_done_d;
  logic        err_sof_q, err_sof_d;
  logic        err_eol_q, err_eol_d;

  logic [VID_DATA_SIZE-1:0] pix;
  logic ready, fval, lval, beat, sof_hit, eol_hit;

  assign pix = s_axis.tdata;

  // Pixel bits are forced to zero whenever DVAL is low.
  function automatic logic [27:0] map_word(input logic [15:0] p, input logic fv,
                                           input logic lv, input logic dv);
    logic [27:0] w;
    w = '0;
    if (dv) begin
      w[4:0] = p[12:8];
      w[6]   = p[13];
      w[27]  = p[14];
      w[5]   = p[15];
      w[7]   = p[0];
      w[8]   = p[1];
      w[9]   = p[2];
      w[12]  = p[3];
      w[13]  = p[4];
      w[14]  = p[5];
      w[10]  = p[6];
      w[11]  = p[7];
    end
    w[24] = lv;
    w[25] = fv;
    w[26] = dv;
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    blank_d = blank_q;
    ready   = 1'b0;
    fval    = 1'b0;
    lval    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Beats ahead of a start-of-frame are swallowed; the SOF beat itself waits.
        ready = s_axis.tvalid & ~s_axis.tuser;
        if (enable && s_axis.tvalid && s_axis.tuser) state_d = StLead;
      end
      StLead: begin
        fval = 1'b1;
        if (blank_q == HBlankLast) begin
          blank_d = '0;
          state_d = StLine;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      StLine: begin
        fval  = 1'b1;
        lval  = 1'b1;
        ready = 1'b1;
        if (s_axis.tvalid) begin
          if (pix_q == PixLast) begin
            pix_d   = '0;
            state_d = StHblank;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      StHblank: begin
        fval = 1'b1;
        if (blank_q == HBlankLast) begin
          blank_d = '0;
          if (line_q == LineLast) begin
            line_d  = '0;
            state_d = StVblank;
          end else begin
            line_d  = line_q + 1'b1;
            state_d = StLine;
          end
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      StVblank: begin
        if (blank_q == VBlankLast) begin
          blank_d = '0;
          state_d = StIdle;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign beat    = (state_q == StLine) & s_axis.tvalid;
  assign sof_hit = beat & s_axis.tuser & ~((pix_q == '0) & (line_q == '0));
  assign eol_hit = beat & (s_axis.tlast != (pix_q == PixLast));

  // A new error in the same cycle as err_clr wins.
  assign err_sof_d    = (err_sof_q & ~err_clr) | sof_hit;
  assign err_eol_d    = (err_eol_q & ~err_clr) | eol_hit;
  assign frame_done_d = (state_q == StVblank) && (blank_q == '0);
  assign data_d       = map_word(pix, fval, lval, beat);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      pix_q        <= '0;
      line_q       <= '0;
      blank_q      <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
      err_eol_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      blank_q      <= blank_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      err_sof_q    <= err_sof_d;
      err_eol_q    <= err_eol_d;
    end
  end

  // tready must read low while reset is held, even though IDLE follows tvalid.
  assign s_axis.tready = aresetn & ready;
  assign Data          = data_q;
  assign frame_done    = frame_done_q;
  assign err_sof       = err_sof_q;
  assign err_eol       = err_eol_q;

endmodule

// File: tb/tb_cl_serialize.sv
// Directed bench for cl_serialize with a shrunk frame: 4 pixels x 3 lines, 2 blank cycles
// per line and 5 vertical blank cycles.
module tb_cl_serialize;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        err_clr;
  logic [27:0] data;
  logic        frame_done;
  logic        err_sof;
  logic        err_eol;

  int checks = 0;
  int errors = 0;

  cl_serialize_if axis ();

  cl_serialize #(
    .VID_DATA_SIZE(16),
    .H_ACTIVE     (4),
    .H_BLANK      (2),
    .V_ACTIVE     (3),
    .VBLANK_CYCLES(5)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .enable    (enable),
    .err_clr   (err_clr),
    .s_axis    (axis),
    .Data      (data),
    .frame_done(frame_done),
    .err_sof   (err_sof),
    .err_eol   (err_eol)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check tready before the edge and registered outputs after it.
  task automatic step(input string tag, input logic v, input logic [15:0] d, input logic u,
                      input logic l, input logic clr, input logic rdy, input logic [27:0] dat,
                      input logic fd, input logic es, input logic ee);
    axis.tvalid = v;
    axis.tdata  = d;
    axis.tuser  = u;
    axis.tlast  = l;
    err_clr     = clr;
    #1;
    chk({tag, ".tready"}, {27'd0, axis.tready}, {27'd0, rdy});
    @(posedge aclk);
    #1;
    chk({tag, ".data"}, data, dat);
    chk({tag, ".frame_done"}, {27'd0, frame_done}, {27'd0, fd});
    chk({tag, ".err_sof"}, {27'd0, err_sof}, {27'd0, es});
    chk({tag, ".err_eol"}, {27'd0, err_eol}, {27'd0, ee});
  endtask

  initial begin
    int          pi;
    logic        is_line;
    logic [27:0] exp;
    logic [15:0] d;

    // Reset with a pre-SOF beat present: tready must still be low.
    aresetn     = 1'b0;
    enable      = 1'b0;
    err_clr     = 1'b0;
    axis.tvalid = 1'b1;
    axis.tdata  = 16'h1234;
    axis.tuser  = 1'b0;
    axis.tlast  = 1'b0;
    #12;
    chk("rst.data", data, 28'h0);
    chk("rst.tready", {27'd0, axis.tready}, 28'h0);
    chk("rst.frame_done", {27'd0, frame_done}, 28'h0);
    chk("rst.err_sof", {27'd0, err_sof}, 28'h0);
    chk("rst.err_eol", {27'd0, err_eol}, 28'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Beats without tuser in IDLE are accepted and dropped.
    for (int i = 0; i < 5; i++) begin
      step($sformatf("presof%0d", i), H, 16'h1234, L, L, L, H, 28'h0, L, L, L);
    end

    // Frame 1: continuous stream, mapping vectors on pixel 0 and on line 1 pixel 1.
    enable = 1'b1;
    step("f1sof", H, 16'hA5C3, H, L, L, L, 28'h0, L, L, L);
    pi = 0;
    for (int c = 1; c <= 26; c++) begin
      is_line = (c >= 3 && c <= 6) || (c >= 9 && c <= 12) || (c >= 15 && c <= 18);
      exp = 28'h0;
      if (is_line) exp = (pi == 0) ? 28'h7000DE5 : (pi == 5) ? 28'hF007FFF : 28'h7000000;
      else if (c <= 20) exp = 28'h2000000;
      d = (pi == 0) ? 16'hA5C3 : (pi == 5) ? 16'hFFFF : 16'h0000;
      step($sformatf("f1c%0d", c), pi < 12, d, pi == 0, (pi % 4) == 3, L, is_line, exp,
           c == 21, L, L);
      if (is_line) pi++;
    end

    // Frame 2: stall, framing errors, err_clr, enable dropped mid-frame.
    step("f2c00", H, 16'h0000, H, L, L, L, 28'h0, L, L, L);
    enable = 1'b0;
    step("f2c01", H, 16'h0000, H, L, L, L, 28'h2000000, L, L, L);
    step("f2c02", H, 16'h0000, H, L, L, L, 28'h2000000, L, L, L);
    step("f2c03", H, 16'h0000, H, L, L, H, 28'h7000000, L, L, L);
    step("f2c04", H, 16'h0000, L, H, L, H, 28'h7000000, L, L, H);
    step("f2c05", L, 16'hFFFF, L, L, L, H, 28'h3000000, L, L, H);
    step("f2c06", L, 16'hFFFF, L, L, L, H, 28'h3000000, L, L, H);
    step("f2c07", L, 16'hFFFF, L, L, L, H, 28'h3000000, L, L, H);
    step("f2c08", H, 16'h0001, L, L, L, H, 28'h7000080, L, L, H);
    step("f2c09", H, 16'h0000, L, H, L, H, 28'h7000000, L, L, H);
    step("f2c10", H, 16'h0100, L, L, L, L, 28'h2000000, L, L, H);
    step("f2c11", H, 16'h0100, L, L, L, L, 28'h2000000, L, L, H);
    step("f2c12", H, 16'h0100, L, L, H, H, 28'h7000001, L, L, L);
    step("f2c13", H, 16'h0000, L, L, L, H, 28'h7000000, L, L, L);
    step("f2c14", H, 16'h0000, L, L, L, H, 28'h7000000, L, L, L);
    step("f2c15", H, 16'h0000, L, L, L, H, 28'h7000000, L, L, H);
    step("f2c16", H, 16'h0000, H, L, L, L, 28'h2000000, L, L, H);
    step("f2c17", H, 16'h0000, H, L, L, L, 28'h2000000, L, L, H);
    step("f2c18", H, 16'h0000, H, L, L, H, 28'h7000000, L, H, H);
    step("f2c19", H, 16'h0000, L, H, H, H, 28'h7000000, L, L, H);
    step("f2c20", H, 16'h0000, L, L, H, H, 28'h7000000, L, L, L);
    step("f2c21", H, 16'h0000, L, H, L, H, 28'h7000000, L, L, L);
    step("f2c22", L, 16'h0000, L, L, L, L, 28'h2000000, L, L, L);
    step("f2c23", L, 16'h0000, L, L, L, L, 28'h2000000, L, L, L);
    step("f2c24", L, 16'h0000, L, L, L, L, 28'h0, H, L, L);
    for (int c = 25; c <= 29; c++) begin
      step($sformatf("f2c%0d", c), L, 16'h0000, L, L, L, L, 28'h0, L, L, L);
    end

    // enable low in IDLE: a SOF must not start a frame.
    step("noen0", H, 16'h0000, H, L, L, L, 28'h0, L, L, L);
    step("noen1", H, 16'h0000, H, L, L, L, 28'h0, L, L, L);

    // Reset during LINE: Data clears at once, block restarts in IDLE.
    enable = 1'b1;
    step("r0", H, 16'hFFFF, H, L, L, L, 28'h0, L, L, L);
    step("r1", H, 16'hFFFF, H, L, L, L, 28'h2000000, L, L, L);
    step("r2", H, 16'hFFFF, H, L, L, L, 28'h2000000, L, L, L);
    step("r3", H, 16'hFFFF, H, L, L, H, 28'hF007FFF, L, L, L);
    step("r4", H, 16'hA5C3, L, L, L, H, 28'h7000DE5, L, L, L);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rmid.data", data, 28'h0);
    chk("rmid.tready", {27'd0, axis.tready}, 28'h0);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    step("r5", H, 16'hA5C3, L, L, L, H, 28'h0, L, L, L);
    step("r6", H, 16'hA5C3, L, L, L, H, 28'h0, L, L, L);
    step("r7", H, 16'hA5C3, H, L, L, L, 28'h0, L, L, L);
    step("r8", H, 16'hA5C3, H, L, L, L, 28'h2000000, L, L, L);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
